color_mapper_palette: RTL

Pipelined, parametrised successor to the mouse colour mapper. Maps a DATA_W-bit per-pixel palette index to 24-bit RGB through a runtime-writable palette, overlays the mouse cursor and a square click marker of configurable size, and registers all outputs. Button inputs are synchronised and edge-detected in the pixel clock domain rather than used as clocks. Sits between the frame-buffer/railway map reader and the VGA DAC.

---
 rtl/color_mapper_palette.sv | 101 ++++++++++
 1 files changed

// File: rtl/color_mapper_palette.sv
// color_mapper_palette: palette lookup with cursor and click-marker overlay, 2-stage registered RGB output
// Ports: Clk/Reset (async active-high); data/is_mouse/DrawX/DrawY pixel stream in;
//        XMOV_MOUSE/YMOV_MOUSE mouse position (Y bottom-up); key1/LEFT/RIGHT async controls;
//        pal_we/pal_addr/pal_wdata palette write; VGA_R/G/B registered colour; mark_vis marker state.
module color_mapper_palette #(
    parameter int          DATA_W     = 2,
    parameter int          MARK_R     = 1,
    parameter int          SCREEN_H   = 480,
    parameter logic [23:0] CURSOR_RGB = 24'h00FFFF,
    parameter logic [23:0] MARK_RGB   = 24'hFF0000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] data,
    input  logic              is_mouse,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        XMOV_MOUSE,
    input  logic [9:0]        YMOV_MOUSE,
    input  logic              key1,
    input  logic              LEFT,
    input  logic              RIGHT,
    input  logic              pal_we,
    input  logic [DATA_W-1:0] pal_addr,
    input  logic [23:0]       pal_wdata,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              mark_vis
);
    localparam int DEPTH = 2 ** DATA_W;
    localparam logic signed [11:0] R = 12'(MARK_R);

    function automatic logic [23:0] pal_init(input int i);
        return i == 0 ? 24'h000000 : i == 2 ? 24'h556D4B : i == 3 ? 24'hFFC3C3 : 24'hFFFFFF;
    endfunction

    logic [2:0]        left_q, right_q;
    logic [1:0]        key_q;
    logic              see_q, see_d, nosee_q, nosee_d;
    logic [23:0]       pal_q [DEPTH];
    logic [DATA_W-1:0] data_q;
    logic              mouse_q, hit_q, hit_d;
    logic [23:0]       rgb_q, rgb_d;
    logic signed [11:0] mx, my, dx, dy;
    logic              hit;

    // Rising edge seen between the 2nd and 3rd sync flop; key1 is taken from its 2nd flop so both line up.
    always_comb begin
        see_d   = (left_q[1] & ~left_q[2]) ? key_q[1] : see_q;
        nosee_d = (right_q[1] & ~right_q[2]) ? ~key_q[1] : nosee_q;
    end

    assign mark_vis = see_q & ~nosee_q;

    // Signed 12-bit distances so coordinates near 0 or 1023 never wrap into a false hit.
    always_comb begin
        mx    = $signed({2'b00, XMOV_MOUSE});
        my    = $signed(12'(SCREEN_H)) - $signed({2'b00, YMOV_MOUSE});
        dx    = $signed({2'b00, DrawX}) - mx;
        dy    = $signed({2'b00, DrawY}) - my;
        hit   = (YMOV_MOUSE <= 10'(SCREEN_H)) && dx >= -R && dx <= R && dy >= -R && dy <= R;
        hit_d = hit & mark_vis & (data == '0);
        rgb_d = mouse_q ? CURSOR_RGB : hit_q ? MARK_RGB : pal_q[data_q];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            left_q  <= '0;
            right_q <= '0;
            key_q   <= '0;
            see_q   <= 1'b0;
            nosee_q <= 1'b0;
            data_q  <= '0;
            mouse_q <= 1'b0;
            hit_q   <= 1'b0;
            rgb_q   <= '0;
        end else begin
            left_q  <= {left_q[1:0], LEFT};
            right_q <= {right_q[1:0], RIGHT};
            key_q   <= {key_q[0], key1};
            see_q   <= see_d;
            nosee_q <= nosee_d;
            data_q  <= data;
            mouse_q <= is_mouse;
            hit_q   <= hit_d;
            rgb_q   <= rgb_d;
        end
    end

    // Stage 2 reads pal_q before this edge's write lands, so a same-edge read sees the old entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) pal_q[i] <= pal_init(i);
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_wdata;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
endmodule
